// File: rtl/pipe_alu.sv
// pipe_alu: single-issue ALU with a one-deep registered result stage.
//
// A new operation is accepted when in_valid && in_ready. Single-cycle ops
// register their result and flags on the accept edge, so out_valid rises one
// cycle later. The result stage holds its contents until out_ready is seen;
// a new accept in the same cycle as a consume replaces the result with no
// bubble.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps its payload stable while
// valid is high and ready is low; ready may depend combinationally on the
// other side's valid/ready.
//
// Optional feature macro: PIPE_ALU_MUL_EN
//   Defined   -> opcode 14 is an unsigned WIDTH x WIDTH multiply (low WIDTH
//                bits), iterative shift-add, one multiplier bit per cycle.
//   Undefined -> no MUL state or multiplier datapath; opcode 14 is illegal.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   in_valid    operation presented
//   in_ready    operation can be accepted this cycle (combinational)
//   in_a, in_b  operands (WIDTH)
//   in_op       opcode (OPW)
//   out_valid   result stage holds an unconsumed result
//   out_ready   downstream consumes the result this cycle
//   out_result  registered result (WIDTH)
//   out_zero, out_carry, out_ovf, out_illegal  registered status flags
//   dbg_state   1 while the multiplier FSM is busy (constant 0 without it)
module pipe_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             dbg_state
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic             accept;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;

`ifdef PIPE_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_nxt;

  assign in_ready  = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign dbg_state = (state_q == S_MUL);
`else
  assign in_ready  = !valid_q || out_ready;
  assign dbg_state = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  // Single-cycle datapath, evaluated on the live inputs; only used on accept.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    sum_w     = {1'b0, in_a} + {1'b0, in_b};
    diff_w    = in_a - in_b;
    case (in_op)
      OPW'(0): begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OPW'(1): begin
        alu_res   = diff_w;
        alu_carry = (in_a < in_b);  // borrow
        alu_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OPW'(2):  alu_res = in_a & in_b;
      OPW'(3):  alu_res = in_a | in_b;
      OPW'(4):  alu_res = ~in_a;
      OPW'(5):  alu_res = ~in_a + WIDTH'(1);
      OPW'(6):  alu_res = in_a << 1;
      OPW'(7):  alu_res = in_a >> 1;
      OPW'(8):  alu_res = {in_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OPW'(9):  alu_res = {{(WIDTH-1){1'b0}}, (in_a != in_b)};
      OPW'(10): alu_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      OPW'(11): alu_res = {{(WIDTH-1){1'b0}}, (!in_a[WIDTH-1] && (in_a != '0))};
      OPW'(12): alu_res = {{(WIDTH-1){1'b0}}, in_a[WIDTH-1]};
      OPW'(13): alu_res = in_a;
      OPW'(15): alu_res = {in_a[WIDTH-1], in_a[WIDTH-1:1]};
      OPW'(28): alu_res = in_a;
      OPW'(29): alu_res = WIDTH'(1);
      default:  alu_ill = 1'b1;
    endcase
  end

  // Next-state for the result stage and (optionally) the multiplier FSM.
  always_comb begin
    valid_d  = valid_q;
    res_d    = res_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifdef PIPE_ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == S_MUL) begin
      // One multiplier bit per cycle; the last step writes straight into
      // the result registers so out_valid rises WIDTH+1 cycles after accept.
      acc_d    = prod_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        res_d   = prod_nxt[WIDTH-1:0];
        zero_d  = (prod_nxt[WIDTH-1:0] == '0);
        carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (accept && (in_op == OPW'(14))) begin
      // Any previous result is consumed this cycle (in_ready implies it).
      state_d  = S_MUL;
      cnt_d    = CW'(WIDTH - 1);
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, in_a};
      mplier_d = in_b;
      valid_d  = 1'b0;
    end else
`endif
    if (accept) begin
      valid_d = 1'b1;
      res_d   = alu_res;
      // Illegal ops report only the illegal flag, so zero stays low there.
      zero_d  = (alu_res == '0) && !alu_ill;
      carry_d = alu_carry;
      ovf_d   = alu_ovf;
      ill_d   = alu_ill;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef PIPE_ALU_MUL_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      valid_q  <= valid_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
`ifdef PIPE_ALU_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_carry   = carry_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_pipe_alu.sv
// Testbench for pipe_alu (WIDTH=16). Covers PIPE_ALU_MUL_EN when defined.
module tb_pipe_alu;
  localparam int W  = 16;
  localparam int EW = W + 4;  // {illegal, ovf, carry, zero, result}
`ifdef PIPE_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [5:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_carry;
  logic         out_ovf;
  logic         out_illegal;
  logic         dbg_state;

  pipe_alu #(.WIDTH(W), .OPW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_illegal(out_illegal),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] pack(input longint r, input bit c, input bit o, input bit il);
    logic [W-1:0] r16;
    r16 = il ? '0 : r[W-1:0];
    return {il, o, c, ((r16 == 0) && !il), r16};
  endfunction

  function automatic logic [EW-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, sa, sb, r, s;
    bit c, o, il;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = 0; c = 0; o = 0; il = 0;
    case (op)
      0:  begin r = ua + ub; c = (r > 65535); s = sa + sb; o = (s > 32767) || (s < -32768); end
      1:  begin r = ua - ub; c = (ua < ub);   s = sa - sb; o = (s > 32767) || (s < -32768); end
      2:  r = longint'(a & b);
      3:  r = longint'(a | b);
      4:  r = 65535 - ua;
      5:  r = 65536 - ua;
      6:  r = ua * 2;
      7:  r = ua / 2;
      8:  r = (ub % 256) * 256;
      9:  r = (ua != ub) ? 1 : 0;
      10: r = (ua == ub) ? 1 : 0;
      11: r = (sa > 0) ? 1 : 0;
      12: r = (sa < 0) ? 1 : 0;
      13: r = ua;
      15: r = (sa - (sa & 1)) / 2;  // floor(sa / 2)
      28: r = ua;
      29: r = 1;
`ifdef PIPE_ALU_MUL_EN
      14: begin r = ua * ub; c = (r > 65535); end
`endif
      default: il = 1;
    endcase
    return pack(r, c, o, il);
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  bit            mon_en = 1'b0;
  logic          mon_ev;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = 1'b0;
      if (exp_q.size() != 0) mon_ev = (cyc >= due_q[0]);
      chk("out_valid", out_valid, mon_ev);
      if (out_valid && mon_ev) begin
        chk("result_flags", {out_illegal, out_ovf, out_carry, out_zero, out_result}, exp_q[0]);
        if (!out_ready) begin
          chk("in_ready_stall", in_ready, 1'b0);
        end else begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  bit rand_rdy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit use_exp, input logic [EW-1:0] exp_v);
    int k;
    int lat;
    in_valid = 1'b1;
    in_op    = op[5:0];
    in_a     = a;
    in_b     = b;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 100) begin
        chk("accept_wait", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
    end
    lat = (MUL_EN && op == 14) ? W + 1 : 1;
    exp_q.push_back(use_exp ? exp_v : model(op, a, b));
    due_q.push_back(cyc + lat);
    @(posedge clk);
    #1;
    // Inputs wander after accept; they must not affect anything.
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_op    = 6'($urandom);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] edge_v[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  initial begin
    int op;
    int r;
    logic [W-1:0] a, b;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {out_illegal, out_ovf, out_carry, out_zero, out_result}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_state", dbg_state, 1'b0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    send(0,  16'hFFFF, 16'h0001, 1'b1, pack(16'h0000, 1'b1, 1'b0, 1'b0));
    send(1,  16'h8000, 16'h0001, 1'b1, pack(16'h7FFF, 1'b0, 1'b1, 1'b0));
    send(15, 16'h8004, 16'h0000, 1'b1, pack(16'hC002, 1'b0, 1'b0, 1'b0));
    send(8,  16'h0000, 16'h12AB, 1'b1, pack(16'hAB00, 1'b0, 1'b0, 1'b0));
    send(20, 16'h1234, 16'h5678, 1'b1, pack(0, 1'b0, 1'b0, 1'b1));
`ifdef PIPE_ALU_MUL_EN
    send(14, 16'h0123, 16'h0010, 1'b1, pack(16'h1230, 1'b0, 1'b0, 1'b0));
    send(14, 16'h0100, 16'h0100, 1'b1, pack(16'h0000, 1'b1, 1'b0, 1'b0));
`else
    send(14, 16'h0123, 16'h0010, 1'b1, pack(0, 1'b0, 1'b0, 1'b1));
`endif
    drain();

    // Back-to-back with backpressure from the second cycle
    send(0, 16'h1111, 16'h2222, 1'b0, '0);
    out_ready = 1'b0;
    fork
      begin
        send(2, 16'hF0F0, 16'h0FF0, 1'b0, '0);
        send(3, 16'hF000, 16'h000F, 1'b0, '0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      op = $urandom_range(0, 15);
      else if (r < 8) op = (r == 6) ? 28 + $urandom_range(0, 1) : 13 + $urandom_range(0, 1);
      else            op = $urandom_range(0, 63);
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
      send(op, a, b, 1'b0, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    drain();

    // Reset in the middle of an operation
`ifdef PIPE_ALU_MUL_EN
    out_ready = 1'b1;
    send(14, 16'h0123, 16'h0010, 1'b0, '0);
`else
    out_ready = 1'b0;
    send(0, 16'h0005, 16'h0007, 1'b0, '0);
`endif
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_outputs", {out_illegal, out_ovf, out_carry, out_zero, out_result}, '0);
    chk("arst_state", dbg_state, 1'b0);
    exp_q.delete();
    due_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_valid", out_valid, 1'b0);
    mon_en    = 1'b1;
    out_ready = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    send(10, 16'h00AA, 16'h00AA, 1'b0, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal values are even numbers from 8 to 64.
REQ-002 Parameter OPW, default 6: opcode width in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept a new operation this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands A and B.
REQ-008 in_op  input  OPW  operation code.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 out_result  output  WIDTH  registered result.
REQ-012 out_zero, out_carry, out_ovf, out_illegal  output  1 each  registered status flags.

Function
REQ-013 Accept occurs when in_valid and in_ready are both high; in_ready = (state==IDLE) and (!out_valid or out_ready), combinational.
REQ-014 Opcodes: 0 A+B, 1 A-B, 2 A&B, 3 A|B, 4 ~A, 5 ~A+1, 6 A<<1, 7 A>>1 logical, 8 {B[WIDTH/2-1:0], WIDTH/2 zeros}, 9 (A!=B), 10 (A==B), 11 signed A>0, 12 signed A<0, 13 A, 28 A, 29 constant 1; compare results are zero-extended to WIDTH.
REQ-015 Opcode 15 (new): arithmetic right shift of A by 1 (sign bit replicated).
REQ-016 Every other opcode, including 14 when multiply is compiled out, gives out_result=0 and out_illegal=1; all other flags are 0.
REQ-017 Single-cycle ops: the result and flags are registered on the accept edge; out_valid rises one cycle after accept (latency 1).
REQ-018 With out_ready held high, throughput is one single-cycle op per clock.
REQ-019 out_zero=1 when out_result==0.
REQ-020 out_carry: carry-out for op 0; borrow (unsigned A<B) for op 1; 0 for all other ops.
REQ-021 out_ovf: signed overflow for ops 0 and 1; 0 for all other ops.
REQ-022 While out_valid=1 and out_ready=0, out_result and all flags hold stable and in_ready=0.
REQ-023 out_valid clears on an out_ready cycle unless a new accept happens in the same cycle, in which case the new result replaces the old one without a bubble.
REQ-024 Inputs are sampled only on accept; changes at any other time have no effect.

Reset
REQ-025 On reset: state=IDLE, out_valid=0, out_result=0, all flags=0, multiply counter and accumulator=0.
REQ-026 Reset asserted mid-multiply aborts the operation; no result is emitted after reset deasserts.
REQ-027 in_ready may be high in the first cycle after reset deasserts.

Configuration
REQ-028 Macro PIPE_ALU_MUL_EN: when defined, opcode 14 is unsigned multiply A*B, low WIDTH bits, iterative shift-add, one multiplier bit per cycle.
REQ-029 With the macro defined: on accept of op 14, state goes IDLE->MUL with the counter loaded to WIDTH-1; in_ready=0 throughout MUL.
REQ-030 With the macro defined: the counter reaching 0 loads the result registers; out_valid rises WIDTH+1 cycles after accept and state returns to IDLE; out_carry=1 if any product bit above WIDTH-1 is nonzero; out_ovf=0.
REQ-031 Without the macro: no MUL state or multiplier logic exists, and op 14 follows REQ-016.

Verification (WIDTH=16)
REQ-032 op0, A=0xFFFF, B=0x0001, out_ready=1 -> next cycle out_valid=1, result 0x0000, zero=1, carry=1, ovf=0.
REQ-033 op1, A=0x8000, B=0x0001 -> result 0x7FFF, ovf=1, carry=0; op15, A=0x8004 -> 0xC002.
REQ-034 op8, B=0x12AB -> 0xAB00; op 20 -> result 0, illegal=1.
REQ-035 Back-to-back ops 0,2,3 with out_ready=0 from cycle 2 -> first result held stable, in_ready=0, no result lost; on release, results appear in order, one per cycle.
REQ-036 PIPE_ALU_MUL_EN defined: op14, A=0x0123, B=0x0010 -> out_valid exactly 17 cycles after accept, result 0x1230, carry=0; A=B=0x0100 -> result 0x0000, carry=1.
REQ-037 Reset pulsed 5 cycles into a multiply -> out_valid stays 0 and in_ready=1 in the first cycle after reset deasserts.
